// File: rtl/multi_timer_pkg.sv
// multi_timer_pkg: shared encodings for the multi-channel timer peripheral.
// FSM states, register offsets, CTRL field positions and MODE codes.
package multi_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    REG_CTRL   = 2'd0,
    REG_PRESET = 2'd1,
    REG_COUNT  = 2'd2,
    REG_STATUS = 2'd3
  } reg_e;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;
  localparam int CTRL_PSC_LO  = 8;
  localparam int CTRL_PSC_HI  = 15;
  localparam int PSC_W        = CTRL_PSC_HI - CTRL_PSC_LO + 1;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  // Only the exact auto-reload code reloads; 1x falls back to one-shot.
  function automatic logic is_reload(input logic [1:0] mode);
    return mode == MODE_RELOAD;
  endfunction

endpackage

// File: rtl/multi_timer_if.sv
// multi_timer_if: CPU bridge bus and interrupt lines of the timer peripheral.
interface multi_timer_if #(
  parameter int NUM_CH = 2
);
  logic [31:2]       Addr;
  logic              WE;
  logic [31:0]       Din;
  logic [31:0]       Dout;
  logic              IRQ;
  logic [NUM_CH-1:0] irq_vec;

  modport master (output Addr, WE, Din, input Dout, IRQ, irq_vec);
  modport slave  (input Addr, WE, Din, output Dout, IRQ, irq_vec);
endinterface

// File: rtl/timer_channel.sv
// timer_channel: one down-counter channel with CTRL/PRESET/COUNT/STATUS,
// its IDLE/LOAD/CNT/INT FSM and, with MULTI_TIMER_PRESCALE_EN defined,
// an 8-bit prescaler gating each count step.
module timer_channel
  import multi_timer_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_i,     // bus write addressed to this channel
  input  reg_e        reg_i,
  input  logic [31:0] din_i,
  output logic [31:0] rdata_o,
  output logic        irq_o
);

  state_e             state_q;
  logic               en_q;
  logic [1:0]         mode_q;
  logic               im_q;
  logic [CNT_W-1:0]   preset_q;
  logic [CNT_W-1:0]   count_q;
  logic               pend_q;
  logic               step;

`ifdef MULTI_TIMER_PRESCALE_EN
  logic [PSC_W-1:0]   psc_q;
  logic [PSC_W-1:0]   psc_cnt_q;
  assign step = (psc_cnt_q == psc_q);
`else
  assign step = 1'b1;
`endif

  // Registers and FSM; a bus write to this channel freezes the FSM for that cycle.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      en_q      <= 1'b0;
      mode_q    <= MODE_ONESHOT;
      im_q      <= 1'b0;
      preset_q  <= '0;
      count_q   <= '0;
      pend_q    <= 1'b0;
`ifdef MULTI_TIMER_PRESCALE_EN
      psc_q     <= '0;
      psc_cnt_q <= '0;
`endif
    end else if (wr_i) begin
      unique case (reg_i)
        REG_CTRL: begin
          en_q   <= din_i[CTRL_EN];
          mode_q <= din_i[CTRL_MODE_HI:CTRL_MODE_LO];
          im_q   <= din_i[CTRL_IM];
`ifdef MULTI_TIMER_PRESCALE_EN
          psc_q  <= din_i[CTRL_PSC_HI:CTRL_PSC_LO];
`endif
        end
        REG_PRESET: preset_q <= din_i[CNT_W-1:0];
        // Expiry cannot land in a write cycle (frozen), so clearing here never
        // loses a set: the expiry simply retires one cycle later.
        REG_STATUS: if (din_i[0]) pend_q <= 1'b0;
        default: ;  // COUNT is read-only
      endcase
    end else begin
      unique case (state_q)
        ST_IDLE: if (en_q) state_q <= ST_LOAD;
        ST_LOAD: begin
          count_q   <= preset_q;
`ifdef MULTI_TIMER_PRESCALE_EN
          psc_cnt_q <= '0;
`endif
          state_q   <= ST_CNT;
        end
        ST_CNT: begin
          if (!en_q) begin
            state_q <= ST_IDLE;
          end else begin
`ifdef MULTI_TIMER_PRESCALE_EN
            psc_cnt_q <= step ? '0 : psc_cnt_q + 1'b1;
`endif
            if (step) begin
              if (count_q > CNT_W'(1)) begin
                count_q <= count_q - CNT_W'(1);
              end else begin
                count_q <= '0;
                pend_q  <= 1'b1;
                state_q <= ST_INT;
              end
            end
          end
        end
        ST_INT: begin
          if (is_reload(mode_q)) begin
            state_q <= ST_LOAD;
          end else begin
            en_q    <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Register read view, zero-extended to the bus width.
  // NOTE: rdata_o gets a full default first so no path leaves it unassigned
  // (which would infer a latch).
  always_comb begin
    rdata_o = '0;
    unique case (reg_i)
      REG_CTRL: begin
        rdata_o[CTRL_EN]                   = en_q;
        rdata_o[CTRL_MODE_HI:CTRL_MODE_LO] = mode_q;
        rdata_o[CTRL_IM]                   = im_q;
`ifdef MULTI_TIMER_PRESCALE_EN
        rdata_o[CTRL_PSC_HI:CTRL_PSC_LO]   = psc_q;
`endif
      end
      REG_PRESET: rdata_o = 32'(preset_q);
      REG_COUNT:  rdata_o = 32'(count_q);
      REG_STATUS: rdata_o[0] = pend_q;
      default: ;
    endcase
  end

  assign irq_o = pend_q & im_q;

  logic unused_din;
  assign unused_din = ^din_i;

endmodule

// File: rtl/multi_timer.sv
// multi_timer: NUM_CH-channel timer peripheral on the CPU bridge.
// Decodes Addr[6:4] (channel) / Addr[3:2] (register), muxes read data and
// ORs the masked channel interrupts. Optional prescaler: MULTI_TIMER_PRESCALE_EN.
module multi_timer
  import multi_timer_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 32
) (
  input logic          clk,
  input logic          reset,
  multi_timer_if.slave bus
);

  logic [2:0]        ch_sel;
  reg_e              reg_sel;
  logic [31:0]       rdata [NUM_CH];
  logic [NUM_CH-1:0] irq_vec;

  assign ch_sel  = bus.Addr[6:4];
  assign reg_sel = reg_e'(bus.Addr[3:2]);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    timer_channel #(.CNT_W(CNT_W)) u_ch (
      .clk     (clk),
      .reset   (reset),
      .wr_i    (bus.WE && (ch_sel == 3'(i))),
      .reg_i   (reg_sel),
      .din_i   (bus.Din),
      .rdata_o (rdata[i]),
      .irq_o   (irq_vec[i])
    );
  end

  // Read mux; unpopulated channels read as zero.
  always_comb begin
    bus.Dout = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_sel == 3'(i)) bus.Dout = rdata[i];
    end
  end

  assign bus.irq_vec = irq_vec;
  assign bus.IRQ     = |irq_vec;

  logic unused_addr;
  assign unused_addr = ^bus.Addr[31:7];

endmodule

// File: tb/tb_multi_timer.sv
// tb_multi_timer: directed scoreboard bench for multi_timer (NUM_CH = 2).
// Inputs change on the falling edge; outputs are sampled 1 ns after it.
module tb_multi_timer;
  import multi_timer_pkg::*;

  logic clk;
  logic reset;

  multi_timer_if #(.NUM_CH(2)) bus ();

  multi_timer #(.NUM_CH(2), .CNT_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic sb_push(input string tag, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    n_tests++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty: observed 0x%08h with no expectation", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp) else begin
        n_fail++;
        $error("FAIL %s: observed 0x%08h expected 0x%08h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_addr(input int ch, input int r);
    bus.Addr      = '0;
    bus.Addr[6:4] = 3'(ch);
    bus.Addr[3:2] = 2'(r);
  endtask

  // One bus write occupying exactly one rising edge.
  task automatic wr(input int ch, input int r, input logic [31:0] d);
    set_addr(ch, r);
    bus.Din = d;
    bus.WE  = 1'b1;
    @(negedge clk);
    bus.WE  = 1'b0;
  endtask

  task automatic chk_rd(input string tag, input int ch, input int r, input logic [31:0] exp);
    sb_push(tag, exp);
    set_addr(ch, r);
    #1;
    check(bus.Dout);
  endtask

  task automatic chk_irq(input string tag, input logic exp_irq, input logic [1:0] exp_vec);
    sb_push({tag, "_irq"}, 32'(exp_irq));
    #1;
    check(32'(bus.IRQ));
    sb_push({tag, "_vec"}, 32'(exp_vec));
    check(32'(bus.irq_vec));
  endtask

  localparam int R_CTRL = 0, R_PRE = 1, R_CNT = 2, R_ST = 3;

  initial begin
    reset   = 1'b1;
    bus.WE  = 1'b0;
    bus.Din = '0;
    bus.Addr = '0;
    tick(3);

    // Reset state
    chk_rd("rst_ctrl0", 0, R_CTRL, 32'h0);
    chk_rd("rst_pre1", 1, R_PRE, 32'h0);
    chk_rd("rst_cnt0", 0, R_CNT, 32'h0);
    chk_irq("rst", 1'b0, 2'b00);
    reset = 1'b0;
    tick(1);

    // Ch0 one-shot, PRESET 5: PEND exactly 7 edges after the CTRL write
    wr(0, R_PRE, 32'd5);
    wr(0, R_CTRL, 32'h9);
    tick(6);
    chk_rd("os_pend_early", 0, R_ST, 32'h0);
    tick(1);
    chk_rd("os_pend", 0, R_ST, 32'h1);
    chk_irq("os", 1'b1, 2'b01);
    tick(1);
    chk_rd("os_ctrl_en_cleared", 0, R_CTRL, 32'h8);
    chk_rd("os_count_zero", 0, R_CNT, 32'h0);
    sb_push("os_state_idle", 32'(ST_IDLE));
    check(32'(dut.g_ch[0].u_ch.state_q));
    wr(0, R_ST, 32'h1);
    chk_irq("os_w1c", 1'b0, 2'b00);

    // Ch1 auto-reload, PRESET 3: period 5, W1C between events
    wr(1, R_PRE, 32'd3);
    wr(1, R_CTRL, 32'hB);
    tick(4);
    chk_rd("ar_pend_early", 1, R_ST, 32'h0);
    tick(1);
    chk_irq("ar_first", 1'b1, 2'b10);
    wr(1, R_ST, 32'h1);              // freezes ch1 one cycle while in INT
    chk_irq("ar_cleared", 1'b0, 2'b00);
    tick(4);
    chk_rd("ar_pend_gap", 1, R_ST, 32'h0);
    tick(1);
    chk_irq("ar_second", 1'b1, 2'b10);
    tick(2);
    chk_rd("ar_reload_cnt", 1, R_CNT, 32'd3);
    tick(2);
    chk_rd("ar_cnt_1", 1, R_CNT, 32'd1);

    // Both pending, ch0 masked
    wr(0, R_PRE, 32'd2);
    wr(0, R_CTRL, 32'h1);
    tick(5);
    chk_irq("mask", 1'b1, 2'b10);
    wr(1, R_ST, 32'h1);
    chk_irq("mask_clr1", 1'b0, 2'b00);
    chk_rd("mask_ch0_pend", 0, R_ST, 32'h1);
    wr(0, R_ST, 32'h2);              // bit0 = 0: no effect
    chk_rd("w0_no_clear", 0, R_ST, 32'h1);
    wr(1, R_CTRL, 32'h0);
    tick(10);
    wr(1, R_ST, 32'h1);
    chk_rd("ch1_stopped_clear", 1, R_ST, 32'h0);

    // W1C on the expiry cycle: PEND still ends up set
    wr(1, R_PRE, 32'd3);
    wr(1, R_CTRL, 32'h9);
    tick(4);
    wr(1, R_ST, 32'h1);
    tick(2);
    chk_rd("w1c_vs_set", 1, R_ST, 32'h1);
    chk_irq("w1c_vs_set", 1'b1, 2'b10);
    wr(1, R_ST, 32'h1);

    // PRESET rewrite mid-count on ch0 auto-reload
    wr(0, R_ST, 32'h1);
    wr(0, R_PRE, 32'd10);
    wr(0, R_CTRL, 32'h3);
    tick(3);
    chk_rd("pre_mid_cnt9", 0, R_CNT, 32'd9);
    wr(0, R_PRE, 32'd100);
    chk_rd("pre_freeze_cnt9", 0, R_CNT, 32'd9);
    tick(8);
    chk_rd("pre_old_cnt1", 0, R_CNT, 32'd1);
    chk_rd("pre_old_pend0", 0, R_ST, 32'h0);
    tick(1);
    chk_rd("pre_old_pend1", 0, R_ST, 32'h1);
    tick(2);
    chk_rd("pre_new_load", 0, R_CNT, 32'd100);
    tick(1);
    chk_rd("pre_new_dec", 0, R_CNT, 32'd99);

    // Reset mid-count at COUNT 40; COUNT writes ignored
    wr(1, R_PRE, 32'd50);
    wr(1, R_CTRL, 32'h9);
    tick(12);
    chk_rd("rst_mid_cnt40", 1, R_CNT, 32'd40);
    wr(1, R_CNT, 32'd7);
    chk_rd("cnt_write_ignored", 1, R_CNT, 32'd40);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk_rd("rst_mid_cnt1", 1, R_CNT, 32'h0);
    chk_rd("rst_mid_cnt0", 0, R_CNT, 32'h0);
    chk_rd("rst_mid_ctrl0", 0, R_CTRL, 32'h0);
    chk_rd("rst_mid_pre0", 0, R_PRE, 32'h0);
    chk_rd("rst_mid_st0", 0, R_ST, 32'h0);
    chk_rd("rst_mid_ctrl1", 1, R_CTRL, 32'h0);
    chk_irq("rst_mid", 1'b0, 2'b00);
    sb_push("rst_mid_state1", 32'(ST_IDLE));
    check(32'(dut.g_ch[1].u_ch.state_q));

    // Unpopulated channel 5
    wr(5, R_PRE, 32'h1234);
    wr(5, R_CTRL, 32'h9);
    chk_rd("ch5_pre", 5, R_PRE, 32'h0);
    chk_rd("ch5_ctrl", 5, R_CTRL, 32'h0);
    tick(4);
    chk_rd("ch5_no_alias_pre0", 0, R_PRE, 32'h0);
    chk_rd("ch5_no_alias_ctrl1", 1, R_CTRL, 32'h0);
    chk_rd("ch5_no_alias_cnt1", 1, R_CNT, 32'h0);
    chk_irq("ch5", 1'b0, 2'b00);

`ifdef MULTI_TIMER_PRESCALE_EN
    wr(0, R_CTRL, 32'h0000FF08);
    chk_rd("psc_field_rw", 0, R_CTRL, 32'h0000FF08);
    wr(0, R_PRE, 32'd4);
    wr(0, R_CTRL, 32'h0000_0209);  // LOAD occurs 2 edges after this write
    tick(13);
    chk_rd("psc_pend_early", 0, R_ST, 32'h0);
    tick(1);
    chk_rd("psc_pend", 0, R_ST, 32'h1);
`else
    wr(0, R_CTRL, 32'h0000FF08);
    chk_rd("psc_field_absent", 0, R_CTRL, 32'h0000_0008);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
